// File: rtl/seq_div8_pkg.sv
// seq_div8_pkg: shared constants, FSM encoding and sign helper for the divider.
// Rev 1.0
`default_nettype none

package seq_div8_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  localparam logic [WIDTH_DEF-1:0] C_DIV0_QUOT = {WIDTH_DEF{1'b1}};

  // Two's-complement negate when neg is set; passes the value through otherwise.
  function automatic logic [WIDTH_DEF-1:0] neg_if(input logic neg,
                                                  input logic [WIDTH_DEF-1:0] val);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_div8_if.sv
// seq_div8_if: start/done request and result bus between the ALU decoder and the divider.
// Rev 1.0 -- is_signed exists only when SEQ_DIV8_SIGNED_EN is defined.
`default_nettype none

interface seq_div8_if #(
  parameter int WIDTH = seq_div8_pkg::WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV8_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
`ifdef SEQ_DIV8_SIGNED_EN
    output is_signed,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef SEQ_DIV8_SIGNED_EN
    input  is_signed,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_div8_div_sub_step.sv
// div_sub_step: one restoring trial subtract, a - b as a WIDTH+1-bit add with explicit borrow.
// Rev 1.0
`default_nettype none

module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH:0] sum_d;

  // Extended MSB of the sum is 1 exactly when b > a.
  always_comb begin
    sum_d    = {1'b0, a_i} + {1'b1, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    diff_o   = sum_d[WIDTH-1:0];
    borrow_o = sum_d[WIDTH];
  end

endmodule

`default_nettype wire

// File: rtl/seq_div8.sv
// seq_div8: iterative restoring divider, one quotient bit per clock, start/done handshake.
// Rev 1.0 -- define SEQ_DIV8_SIGNED_EN for truncating signed division via is_signed.
`default_nettype none

module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_div8_if.slave  div_io
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] qsh_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] shifted_d;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] qsh_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic             neg_quo_d;
  logic             neg_rem_d;

  // Partial remainder stays below 2^(WIDTH-1) until the final shift, so its MSB is never lost.
  assign shifted_d = {rem_q[WIDTH-2:0], qsh_q[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_sub_step (
    .a_i      (shifted_d),
    .b_i      (dvs_q),
    .diff_o   (diff_d),
    .borrow_o (borrow_d)
  );

  always_comb begin
    rem_d = borrow_d ? shifted_d : diff_d;
    qsh_d = {qsh_q[WIDTH-2:0], ~borrow_d};
`ifdef SEQ_DIV8_SIGNED_EN
    neg_rem_d = div_io.is_signed & div_io.dividend[WIDTH-1];
    neg_quo_d = neg_rem_d ^ (div_io.is_signed & div_io.divisor[WIDTH-1]);
    dvd_mag_d = neg_if(neg_rem_d, div_io.dividend);
    dvs_mag_d = neg_if(div_io.is_signed & div_io.divisor[WIDTH-1], div_io.divisor);
`else
    neg_rem_d = 1'b0;
    neg_quo_d = 1'b0;
    dvd_mag_d = div_io.dividend;
    dvs_mag_d = div_io.divisor;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qsh_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (div_io.start) begin
            dbz_q <= 1'b0;
            if (div_io.divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= C_DIV0_QUOT;
              remainder_q <= div_io.dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              rem_q     <= '0;
              qsh_q     <= dvd_mag_d;
              dvs_q     <= dvs_mag_d;
              cnt_q     <= CNT_W'(WIDTH);
              neg_quo_q <= neg_quo_d;
              neg_rem_q <= neg_rem_d;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          qsh_q <= qsh_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= neg_if(neg_quo_q, qsh_d);
            remainder_q <= neg_if(neg_rem_q, rem_d);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_io.busy        = busy_q;
  assign div_io.done        = done_q;
  assign div_io.quotient    = quotient_q;
  assign div_io.remainder   = remainder_q;
  assign div_io.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_div8.sv
// tb_seq_div8: directed self-checking bench for seq_div8 (latency, results, handshake, reset).
// Rev 1.0
`default_nettype none

module tb_seq_div8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  seq_div8_if #(.WIDTH(8)) dif ();

  seq_div8 #(.WIDTH(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_io (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and follow it to done; entered and left 1 time unit after a clock edge.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat);
    int n;
    int nbusy;
    n     = 1;
    nbusy = 0;
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    tick();
    dif.start = 1'b0;
    while (!dif.done && n < 20) begin
      if (dif.busy) nbusy++;
      tick();
      n++;
    end
    chk({tag, "_lat"},  n,             elat);
    chk({tag, "_busy"}, nbusy,         elat - 1);
    chk({tag, "_q"},    dif.quotient,  {24'd0, eq});
    chk({tag, "_r"},    dif.remainder, {24'd0, er});
    chk({tag, "_dbz"},  dif.div_by_zero, {31'd0, edbz});
  endtask

  initial begin
    int seen;
    int n;
    logic [7:0] ra;
    logic [7:0] rb;
    n_cmp = 0;
    n_err = 0;
    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = 8'd0;
    dif.divisor  = 8'd0;
`ifdef SEQ_DIV8_SIGNED_EN
    dif.is_signed = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", dif.busy, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_q",    dif.quotient, 0);
    chk("rst_r",    dif.remainder, 0);
    chk("rst_dbz",  dif.div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    do_div("basic",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9);
    tick();
    chk("basic_done_pulse", dif.done, 0);
    chk("basic_hold_q",     dif.quotient, 28);

    // Asynchronous reset in the middle of a run.
    dif.start = 1'b1; dif.dividend = 8'd200; dif.divisor = 8'd7;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", dif.busy, 0);
    chk("mid_rst_q",    dif.quotient, 0);
    chk("mid_rst_r",    dif.remainder, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dif.done || dif.busy) seen++;
      tick();
    end
    chk("mid_rst_quiet", seen, 0);
    do_div("after_rst", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);

    do_div("b255_1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9);
    do_div("b5_9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9);
    do_div("b255_255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9);
    do_div("dbz",      8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1);
    do_div("post_dbz", 8'd100, 8'd10,  8'd10,  8'd0,  1'b0, 9);

    // start held high; operand changes mid-run must be ignored until the DONE cycle.
    dif.start = 1'b1; dif.dividend = 8'd100; dif.divisor = 8'd3;
    tick();
    n = 1;
    while (!dif.done && n < 20) begin
      if (n == 4) begin
        dif.dividend = 8'd250;
        dif.divisor  = 8'd10;
      end
      tick();
      n++;
    end
    chk("hs_lat1", n, 9);
    chk("hs_q1",   dif.quotient, 33);
    chk("hs_r1",   dif.remainder, 1);
    tick();
    dif.start = 1'b0;
    chk("hs_busy2",   dif.busy, 1);
    chk("hs_hold_q1", dif.quotient, 33);
    n = 1;
    while (!dif.done && n < 20) begin
      tick();
      n++;
    end
    chk("hs_lat2", n, 9);
    chk("hs_q2",   dif.quotient, 25);
    chk("hs_r2",   dif.remainder, 0);

`ifdef SEQ_DIV8_SIGNED_EN
    dif.is_signed = 1'b1;
    do_div("s_m100_7",  8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 9);
    do_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    do_div("s_dbz",     8'hF0, 8'd0,  8'hFF, 8'hF0, 1'b1, 1);
    dif.is_signed = 1'b0;
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      do_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 9);
      chk("rand_lt", {31'd0, (dif.remainder < rb)}, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
